// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
//   Shared definitions for the 1x3 router packet-reception controller:
//   state encoding, output-port count and the reserved (invalid) address.
//   Imported by router_fsm and by the other router blocks.
// ---------------------------------------------------------------------------
package router_pkg;

  localparam int         NUM_PORTS    = 3;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

endpackage

// File: rtl/router_fsm.sv
// ---------------------------------------------------------------------------
// router_fsm
//   Packet-reception controller for the 1x3 router. Sequences header decode,
//   payload load, FIFO-full stall and parity load/check for one packet at a
//   time. All outputs are decoded from the state register only.
//
//   state              | meaning
//   -------------------+------------------------------------------------------
//   DECODE_ADDRESS     | idle / header cycle, synchronizer latches din
//   WAIT_TILL_EMPTY    | header seen, waiting for the target FIFO to drain
//   LOAD_FIRST_DATA    | header byte written to FIFO
//   LOAD_DATA          | payload bytes written while pkt_valid is high
//   FIFO_FULL_STATE    | target FIFO full, source held off
//   LOAD_AFTER_FULL    | write the byte held during the stall
//   LOAD_PARITY        | parity byte written
//   CHECK_PARITY_ERROR | parity compare; internal parity registers cleared
//
// Ports
//   clk                      system clock, rising edge
//   rst                      asynchronous active-low reset
//   pkt_valid                source packet-valid (header .. last payload byte)
//   din[ADDR_W-1:0]          header address bits
//   fifo_full                full flag of the selected FIFO
//   fifo_empty_0..2          per-FIFO empty flags
//   soft_reset_0..2          per-FIFO timeout soft resets
//   parity_done              register block captured the parity byte
//   low_pkt_valid            register block saw pkt_valid drop while stalled
//   detect_addr, lfd_state, ld_state, laf_state, full_state,
//   write_enb_reg, rst_int_reg, busy   state-decoded controls
// ---------------------------------------------------------------------------
module router_fsm
  import router_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] din,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_addr,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy
);

  localparam int NUM_ADDR = 1 << ADDR_W;

  state_t            state_q;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [NUM_ADDR-1:0] empty_vec;
  logic [NUM_ADDR-1:0] soft_vec;
  logic              din_valid;
  logic              hdr_accept;

  // Flags padded out to the full address space so that any din/addr_q value
  // indexes in range; unused (invalid) slots read as 0.
  always_comb begin
    empty_vec    = '0;
    soft_vec     = '0;
    empty_vec[0] = fifo_empty_0;
    empty_vec[1] = fifo_empty_1;
    empty_vec[2] = fifo_empty_2;
    soft_vec[0]  = soft_reset_0;
    soft_vec[1]  = soft_reset_1;
    soft_vec[2]  = soft_reset_2;
  end

  assign din_valid  = (din != ADDR_W'(ADDR_INVALID));
  assign hdr_accept = (state_q == DECODE_ADDRESS) && pkt_valid && din_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_nxt;
      if (hdr_accept) addr_q <= din;
    end
  end

  always_comb begin
    state_nxt = state_q;
    // Timeout on the selected FIFO abandons the packet from any busy state.
    if ((state_q != DECODE_ADDRESS) && soft_vec[addr_q]) begin
      state_nxt = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (pkt_valid && din_valid)
            state_nxt = empty_vec[din] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
        WAIT_TILL_EMPTY: begin
          if (empty_vec[addr_q]) state_nxt = LOAD_FIRST_DATA;
        end
        LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
        LOAD_DATA: begin
          // A full FIFO wins over end-of-packet: the last byte must be held.
          if (fifo_full)       state_nxt = FIFO_FULL_STATE;
          else if (!pkt_valid) state_nxt = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) state_nxt = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_nxt = DECODE_ADDRESS;
          else if (low_pkt_valid) state_nxt = LOAD_PARITY;
          else                    state_nxt = LOAD_DATA;
        end
        LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        default: state_nxt = DECODE_ADDRESS;
      endcase
    end
  end

  assign detect_addr   = (state_q == DECODE_ADDRESS);
  assign lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign ld_state      = (state_q == LOAD_DATA);
  assign laf_state     = (state_q == LOAD_AFTER_FULL);
  assign full_state    = (state_q == FIFO_FULL_STATE);
  assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
  assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                         (state_q == LOAD_AFTER_FULL);
  assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm.sv
// ---------------------------------------------------------------------------
// tb_router_fsm
//   Directed, table-driven bench for router_fsm. Each row gives the inputs
//   applied for one clock cycle and the outputs expected during that cycle.
//   Output vector order: {detect_addr, lfd_state, ld_state, laf_state,
//   full_state, write_enb_reg, rst_int_reg, busy}.
// ---------------------------------------------------------------------------
module tb_router_fsm;

  localparam logic [7:0] O_DA   = 8'b1000_0000;
  localparam logic [7:0] O_LFD  = 8'b0100_0001;
  localparam logic [7:0] O_LD   = 8'b0010_0100;
  localparam logic [7:0] O_LAF  = 8'b0001_0101;
  localparam logic [7:0] O_FULL = 8'b0000_1001;
  localparam logic [7:0] O_LP   = 8'b0000_0101;
  localparam logic [7:0] O_CPE  = 8'b0000_0011;
  localparam logic [7:0] O_WTE  = 8'b0000_0001;

  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       full;
    logic [2:0] emp;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic pkt_valid;
  logic [1:0] din;
  logic fifo_full;
  logic fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic soft_reset_0, soft_reset_1, soft_reset_2;
  logic parity_done, low_pkt_valid;
  logic detect_addr, lfd_state, ld_state, laf_state, full_state;
  logic write_enb_reg, rst_int_reg, busy;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  router_fsm #(.ADDR_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_valid     (pkt_valid),
    .din           (din),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_addr   (detect_addr),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .write_enb_reg (write_enb_reg),
    .rst_int_reg   (rst_int_reg),
    .busy          (busy)
  );

  function automatic logic [7:0] outs();
    return {detect_addr, lfd_state, ld_state, laf_state, full_state,
            write_enb_reg, rst_int_reg, busy};
  endfunction

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: outputs=%b expected=%b", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pkt_valid     = v.pv;
    din           = v.din;
    fifo_full     = v.full;
    {fifo_empty_2, fifo_empty_1, fifo_empty_0} = v.emp;
    {soft_reset_2, soft_reset_1, soft_reset_0} = v.sr;
    parity_done   = v.pd;
    low_pkt_valid = v.lpv;
  endtask

  task automatic add(input logic pv, input logic [1:0] d, input logic f,
                     input logic [2:0] e, input logic [2:0] s, input logic pd,
                     input logic lpv, input logic [7:0] exp);
    vec_t v;
    v.pv = pv; v.din = d; v.full = f; v.emp = e; v.sr = s;
    v.pd = pd; v.lpv = lpv; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t idle;
    // Header to port 1 (empty), 4 payload bytes, parity, check.
    add(1, 1, 0, 3'b111, 3'b000, 0, 0, O_DA);
    add(1, 1, 0, 3'b111, 3'b000, 0, 0, O_LFD);
    add(1, 0, 0, 3'b111, 3'b000, 0, 0, O_LD);
    add(1, 0, 0, 3'b111, 3'b000, 0, 0, O_LD);
    add(1, 0, 0, 3'b111, 3'b000, 0, 0, O_LD);
    add(0, 0, 0, 3'b111, 3'b000, 0, 0, O_LD);
    add(0, 0, 0, 3'b111, 3'b000, 0, 0, O_LP);
    add(0, 0, 0, 3'b111, 3'b000, 0, 0, O_CPE);
    add(0, 0, 0, 3'b111, 3'b000, 0, 0, O_DA);
    // Port 0: three-cycle full stall, then resume.
    add(1, 0, 0, 3'b111, 3'b000, 0, 0, O_DA);
    add(1, 0, 0, 3'b111, 3'b000, 0, 0, O_LFD);
    add(1, 0, 1, 3'b111, 3'b000, 0, 0, O_LD);
    add(1, 0, 1, 3'b111, 3'b000, 0, 0, O_FULL);
    add(1, 0, 1, 3'b111, 3'b000, 0, 0, O_FULL);
    add(1, 0, 0, 3'b111, 3'b000, 0, 0, O_FULL);
    add(1, 0, 0, 3'b111, 3'b000, 0, 0, O_LAF);
    // Full and pkt_valid low together: full wins.
    add(0, 0, 1, 3'b111, 3'b000, 0, 0, O_LD);
    add(0, 0, 0, 3'b111, 3'b000, 0, 0, O_FULL);
    add(0, 0, 0, 3'b111, 3'b000, 0, 1, O_LAF);
    add(0, 0, 0, 3'b111, 3'b000, 0, 0, O_LP);
    // Full during parity check, then parity_done ends the packet.
    add(0, 0, 1, 3'b111, 3'b000, 0, 0, O_CPE);
    add(0, 0, 0, 3'b111, 3'b000, 0, 0, O_FULL);
    add(0, 0, 0, 3'b111, 3'b000, 1, 1, O_LAF);
    // Port 2 not empty: wait, then load; soft_reset_1 ignored, soft_reset_2 aborts.
    add(1, 2, 0, 3'b011, 3'b000, 0, 0, O_DA);
    add(1, 0, 0, 3'b011, 3'b000, 0, 0, O_WTE);
    add(1, 0, 0, 3'b111, 3'b000, 0, 0, O_WTE);
    add(1, 0, 0, 3'b111, 3'b000, 0, 0, O_LFD);
    add(1, 0, 0, 3'b111, 3'b010, 0, 0, O_LD);
    add(1, 0, 0, 3'b111, 3'b100, 0, 0, O_LD);
    // Invalid address dropped, even with everything empty.
    add(1, 3, 0, 3'b111, 3'b000, 0, 0, O_DA);
    add(1, 3, 0, 3'b111, 3'b000, 0, 0, O_DA);
    add(1, 3, 0, 3'b111, 3'b000, 0, 0, O_DA);
    // Port 1 busy: soft_reset_1 aborts the wait.
    add(1, 1, 0, 3'b101, 3'b000, 0, 0, O_DA);
    add(1, 0, 0, 3'b101, 3'b010, 0, 0, O_WTE);
    add(0, 0, 0, 3'b111, 3'b010, 0, 0, O_DA);
    // Port 0 load: soft_reset_1 ignored, soft_reset_0 aborts.
    add(1, 0, 0, 3'b111, 3'b000, 0, 0, O_DA);
    add(1, 0, 0, 3'b111, 3'b000, 0, 0, O_LFD);
    add(1, 0, 0, 3'b111, 3'b010, 0, 0, O_LD);
    add(1, 0, 0, 3'b111, 3'b001, 0, 0, O_LD);
    add(0, 0, 0, 3'b111, 3'b000, 0, 0, O_DA);

    idle.pv = 0; idle.din = 0; idle.full = 0; idle.emp = 3'b111;
    idle.sr = 3'b000; idle.pd = 0; idle.lpv = 0; idle.exp = O_DA;
    drive(idle);
    rst = 1'b0;
    #12;
    check("reset_values", outs(), O_DA);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Async reset while stalled in FIFO_FULL_STATE, away from any clock edge.
    @(negedge clk);
    pkt_valid = 1; din = 2'd2; fifo_full = 0;
    #1 check("ar_decode", outs(), O_DA);
    @(negedge clk);
    #1 check("ar_lfd", outs(), O_LFD);
    @(negedge clk);
    fifo_full = 1;
    #1 check("ar_ld", outs(), O_LD);
    @(negedge clk);
    #1 check("ar_full", outs(), O_FULL);
    #1 rst = 1'b0;
    #1 check("ar_immediate", outs(), O_DA);
    @(negedge clk);
    #1 check("ar_held", outs(), O_DA);
    pkt_valid = 0; fifo_full = 0;
    rst = 1'b1;
    // Controller usable again after reset: header to port 2 (empty).
    @(negedge clk);
    pkt_valid = 1; din = 2'd2;
    #1 check("post_rst_decode", outs(), O_DA);
    @(negedge clk);
    #1 check("post_rst_lfd", outs(), O_LFD);
    @(negedge clk);
    pkt_valid = 0;
    #1 check("post_rst_ld", outs(), O_LD);
    @(negedge clk);
    #1 check("post_rst_lp", outs(), O_LP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
